mod_data_tx: RTL and testbench
==============================

Name: mod_data_tx

Overview:
- Baseband symbol mapper and transmitter; the transmit-side counterpart of the I/Q demodulator.
- Accepts 4-bit data nibbles over a valid/ready handshake and serialises them into BPSK, QPSK or 16-QAM symbols.
- Each symbol is emitted as registered 5-bit signed I/Q samples, held for SPS clocks.
- Drives the DAC/loopback path whose I/Q format matches the demodulator input.

Parameters:
- SPS, 4, samples per symbol (each symbol held SPS clocks); legal range 1..16.
- W, 5, signed I/Q sample width; mapping constants below assume W=5.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- mod_sel  input  2  modulation select: 00 BPSK, 01 QPSK, 10 16-QAM, 11 reserved
- data_in  input  4  data nibble
- data_valid  input  1  data_in valid
- data_ready  output  1  block accepts nibble this cycle
- i_out  output  W  signed in-phase sample, registered
- q_out  output  W  signed quadrature sample, registered
- sym_strobe  output  1  high on first sample of each symbol, registered
- busy  output  1  symbol in flight, registered

Behaviour:
- One clock domain (clk). Reset is asynchronous, active-low (rst_n). Reset values: state IDLE, i_out=0, q_out=0, sym_strobe=0, busy=0, counters 0, shift register 0.
- States:
  - IDLE: outputs 0, busy=0.
  - TX: a symbol is being emitted.
- Accept occurs when data_valid & data_ready. At accept the block latches the nibble into a 4-bit shift register and latches mod_sel. mod_sel changes after accept do not affect the nibble in flight.
- data_ready = (state==IDLE, or TX on the last sample of the last symbol) AND mod_sel!=11. It is combinational from registered state and the live mod_sel.
- Symbols per nibble: BPSK 4, QPSK 2, 16-QAM 1.
- Bit order, LSB first:
  - BPSK: data[0], [1], [2], [3].
  - QPSK: data[1:0], then data[3:2].
  - 16-QAM: whole nibble.
- Mapping (bit value 0 maps to positive):
  - BPSK: I = b ? -8 : +8; Q = 0.
  - QPSK: I = b0 ? -8 : +8; Q = b1 ? -8 : +8.
  - 16-QAM, Gray coded: I from bits[1:0], Q from bits[3:2]. Codes map 00->-12, 01->-4, 11->+4, 10->+12.
- Latency: accept in cycle N; the first sample of symbol 0 appears on i_out/q_out in cycle N+1 with sym_strobe=1 and busy=1.
- Timing:
  - Each symbol is held exactly SPS cycles; sample counter runs 0..SPS-1.
  - On wrap, advance to the next symbol and pulse sym_strobe.
  - After the last sample of the last symbol: if a new accept happens in that same cycle, the next nibble's symbol 0 starts in the next cycle with no gap. Otherwise go to IDLE, with i_out=q_out=0 and busy=0 in the next cycle.
- SPS=1: every sample is a new symbol; sym_strobe stays high during continuous transmission.
- Reserved mod_sel=11: data_ready stays 0, nothing is accepted, and outputs stay 0 once idle. A nibble already in flight completes normally.
- data_valid without ready: no state change; data_in is not sampled.
- Reset asserted mid-symbol: all outputs clear immediately (asynchronously) and the nibble is discarded. The first accept after release restarts from symbol 0.
- Outputs never carry an X or an out-of-range code; the 16-QAM mapping is a full 4-entry table.

Test Plan:
- BPSK, SPS=4, data_in=4'b1010 accepted at cycle 0:
  - cycles 1-4 I=+8; 5-8 I=-8; 9-12 I=+8; 13-16 I=-8; Q=0 throughout.
  - sym_strobe at cycles 1, 5, 9, 13; data_ready=0 in cycles 1-15 and 1 in cycle 16; idle zeros from cycle 17.
- QPSK, data_in=4'b0110: symbol 0 is I=+8, Q=-8 for 4 cycles; symbol 1 is I=-8, Q=+8 for 4 cycles; then zeros.
- 16-QAM, data_in=4'b1101 and 4'b0010 back-to-back with data_valid held high:
  - I=-4, Q=+4 for 4 cycles, immediately followed by I=+12, Q=-12 for 4 cycles.
  - No zero sample between them; two sym_strobes 4 cycles apart.
- mod_sel=11 with data_valid=1 for 20 cycles: data_ready=0, i_out=q_out=0, busy=0 throughout. Switching to 01 then gives an accept in the same cycle.
- mod_sel toggled from 00 to 10 mid-BPSK nibble: all 4 BPSK symbols complete unchanged; the next nibble is then 16-QAM mapped.
- rst_n pulsed low during cycle 6 of a BPSK nibble:
  - Outputs go to 0 asynchronously, busy=0, no further strobes.
  - After release, a new nibble starts cleanly with one-cycle latency.

Source files
------------

// File: rtl/mod_data_tx.sv
// Baseband symbol mapper: nibbles in over valid/ready, BPSK/QPSK/16-QAM I/Q samples out,
// each symbol held for SPS clocks with a strobe on its first sample.
module mod_data_tx #(
  parameter int SPS = 4,
  parameter int W   = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   mod_sel,
  input  logic [3:0]   data_in,
  input  logic         data_valid,
  output logic         data_ready,
  output logic [W-1:0] i_out,
  output logic [W-1:0] q_out,
  output logic         sym_strobe,
  output logic         busy
);

  typedef enum logic {IDLE, TX} state_t;

  localparam logic [1:0]   MOD_BPSK = 2'b00;
  localparam logic [1:0]   MOD_QPSK = 2'b01;
  localparam logic [1:0]   MOD_QAM  = 2'b10;
  localparam logic [W-1:0] P4  = W'(4);
  localparam logic [W-1:0] P8  = W'(8);
  localparam logic [W-1:0] P12 = W'(12);
  localparam logic [W-1:0] N4  = W'(-4);
  localparam logic [W-1:0] N8  = W'(-8);
  localparam logic [W-1:0] N12 = W'(-12);

  state_t       state_q, state_d;
  logic [3:0]   sr_q, sr_d;
  logic [1:0]   mod_q, mod_d;
  logic [1:0]   sym_q, sym_d;
  logic [3:0]   smp_q, smp_d;
  logic [W-1:0] i_q, i_d, q_q, q_d;
  logic         stb_q, stb_d;
  logic         busy_q, busy_d;

  logic         last_smp, last_sym, accept, start;
  logic [1:0]   sym_last_idx;

  function automatic logic [W-1:0] bit_map(input logic b);
    return b ? N8 : P8;
  endfunction

  // Gray-coded 16-QAM level per 2-bit code
  function automatic logic [W-1:0] qam_map(input logic [1:0] c);
    logic [W-1:0] v;
    case (c)
      2'b00:   v = N12;
      2'b01:   v = N4;
      2'b11:   v = P4;
      default: v = P12;
    endcase
    return v;
  endfunction

  always_comb begin
    case (mod_q)
      MOD_BPSK: sym_last_idx = 2'd3;
      MOD_QPSK: sym_last_idx = 2'd1;
      default:  sym_last_idx = 2'd0;
    endcase
  end

  assign last_smp   = (smp_q == 4'(SPS - 1));
  assign last_sym   = (sym_q == sym_last_idx);
  assign data_ready = ((state_q == IDLE) || (last_smp && last_sym)) && (mod_sel != 2'b11);
  assign accept     = data_valid && data_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      mod_q   <= '0;
      sym_q   <= '0;
      smp_q   <= '0;
      i_q     <= '0;
      q_q     <= '0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      mod_q   <= mod_d;
      sym_q   <= sym_d;
      smp_q   <= smp_d;
      i_q     <= i_d;
      q_q     <= q_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    mod_d   = mod_q;
    sym_d   = sym_q;
    smp_d   = smp_q;
    start   = 1'b0;
    if (state_q == TX && !last_smp) begin
      smp_d = smp_q + 4'd1;
    end else if (state_q == TX && !last_sym) begin
      smp_d = '0;
      sym_d = sym_q + 2'd1;
      sr_d  = (mod_q == MOD_BPSK) ? (sr_q >> 1) : (sr_q >> 2);
      start = 1'b1;
    end else if (accept) begin
      state_d = TX;
      sr_d    = data_in;
      mod_d   = mod_sel;
      sym_d   = '0;
      smp_d   = '0;
      start   = 1'b1;
    end else begin
      state_d = IDLE;
      sym_d   = '0;
      smp_d   = '0;
    end
  end

  // Samples are mapped from the next shift-register value so symbol 0 lands one cycle after accept
  always_comb begin
    i_d    = i_q;
    q_d    = q_q;
    stb_d  = start;
    busy_d = (state_d == TX);
    if (start) begin
      case (mod_d)
        MOD_BPSK: begin i_d = bit_map(sr_d[0]);     q_d = '0;                  end
        MOD_QPSK: begin i_d = bit_map(sr_d[0]);     q_d = bit_map(sr_d[1]);    end
        MOD_QAM:  begin i_d = qam_map(sr_d[1:0]);   q_d = qam_map(sr_d[3:2]);  end
        default:  begin i_d = '0;                   q_d = '0;                  end
      endcase
    end else if (state_d == IDLE) begin
      i_d = '0;
      q_d = '0;
    end
  end

  assign i_out      = i_q;
  assign q_out      = q_q;
  assign sym_strobe = stb_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mod_data_tx.sv
// Scoreboard bench for mod_data_tx: stimulus pushes expected per-sample I/Q/strobe,
// a negedge monitor pops and compares whenever busy is high and checks idle zeros otherwise.
module tb_mod_data_tx;
  localparam int SPS = 4;
  localparam int W   = 5;

  typedef struct { int i; int q; int stb; } smp_t;
  typedef int v4_t [4];

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   mod_sel;
  logic [3:0]   data_in;
  logic         data_valid;
  logic         data_ready;
  logic [W-1:0] i_out, q_out;
  logic         sym_strobe, busy;

  smp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  mod_data_tx #(.SPS(SPS), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .mod_sel(mod_sel), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .i_out(i_out),
    .q_out(q_out), .sym_strobe(sym_strobe), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Caller sits just after a posedge; returns just after the accept edge with data_valid still high.
  task automatic send(input logic [1:0] m, input logic [3:0] d, input int nsym,
                      input v4_t ei, input v4_t eq, output int waited);
    bit got = 0;
    waited = 0;
    mod_sel    = m;
    data_in    = d;
    data_valid = 1'b1;
    while (!got && waited < 60) begin
      @(negedge clk);
      waited++;
      if (data_ready) got = 1;
    end
    if (!got) begin
      chk("accept_timeout", 0, 1);
      data_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      for (int s = 0; s < nsym; s++)
        for (int k = 0; k < SPS; k++) begin
          smp_t e;
          e.i = ei[s]; e.q = eq[s]; e.stb = (k == 0) ? 1 : 0;
          exp_q.push_back(e);
        end
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_busy", 1, 0);
        end else begin
          smp_t e;
          e = exp_q.pop_front();
          chk("i_out", int'($signed(i_out)), e.i);
          chk("q_out", int'($signed(q_out)), e.q);
          chk("sym_strobe", int'(sym_strobe), e.stb);
        end
      end else begin
        chk("idle_i", int'($signed(i_out)), 0);
        chk("idle_q", int'($signed(q_out)), 0);
        chk("idle_strobe", int'(sym_strobe), 0);
        if (rst_n) chk("no_gap_pending", exp_q.size(), 0);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int w;
    rst_n = 1'b0; mod_sel = 2'b00; data_in = 4'h0; data_valid = 1'b0;
    #3;
    chk("rst_i", int'(i_out), 0);
    chk("rst_q", int'(q_out), 0);
    chk("rst_strobe", int'(sym_strobe), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // BPSK 1010 and its data_ready profile
    send(2'b00, 4'b1010, 4, '{8, -8, 8, -8}, '{0, 0, 0, 0}, w);
    data_valid = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      chk("bpsk_ready_low", int'(data_ready), 0);
    end
    @(negedge clk);
    chk("bpsk_ready_last", int'(data_ready), 1);
    @(posedge clk); #1;
    repeat (3) @(posedge clk); #1;

    // QPSK 0110
    send(2'b01, 4'b0110, 2, '{8, -8, 0, 0}, '{-8, 8, 0, 0}, w);
    data_valid = 1'b0;
    repeat (10) @(posedge clk); #1;

    // 16-QAM back-to-back
    send(2'b10, 4'b1101, 1, '{-4, 0, 0, 0}, '{4, 0, 0, 0}, w);
    send(2'b10, 4'b0010, 1, '{12, 0, 0, 0}, '{-12, 0, 0, 0}, w);
    chk("qam_b2b_wait", w, SPS);
    data_valid = 1'b0;
    repeat (8) @(posedge clk); #1;

    // Reserved mode blocks acceptance
    mod_sel = 2'b11; data_in = 4'hF; data_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("rsv_ready", int'(data_ready), 0);
      chk("rsv_busy", int'(busy), 0);
    end
    @(posedge clk); #1;
    send(2'b01, 4'b1001, 2, '{-8, 8, 0, 0}, '{8, -8, 0, 0}, w);
    chk("rsv_release_accept", w, 1);
    data_valid = 1'b0;
    repeat (10) @(posedge clk); #1;

    // mod_sel change mid-nibble, then a 16-QAM nibble chained on
    send(2'b00, 4'b0011, 4, '{-8, -8, 8, 8}, '{0, 0, 0, 0}, w);
    data_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    mod_sel = 2'b10;
    send(2'b10, 4'b1110, 1, '{12, 0, 0, 0}, '{4, 0, 0, 0}, w);
    data_valid = 1'b0;
    repeat (8) @(posedge clk); #1;

    // Async reset during cycle 6 of a BPSK nibble
    send(2'b00, 4'b0101, 4, '{-8, 8, -8, 8}, '{0, 0, 0, 0}, w);
    data_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_i", int'(i_out), 0);
    chk("arst_q", int'(q_out), 0);
    chk("arst_strobe", int'(sym_strobe), 0);
    chk("arst_busy", int'(busy), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(2'b00, 4'b1100, 4, '{8, 8, -8, -8}, '{0, 0, 0, 0}, w);
    chk("post_reset_accept", w, 1);
    data_valid = 1'b0;
    repeat (20) @(posedge clk); #1;

    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
